// File: rtl/coilgun_core_pkg.sv
// Shared types and constants for the coilgun firing controller.
package cg_core_pkg;

    localparam int CW = 24;
    localparam logic [CW-1:0] ACC_MAX = {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        FIRE,
        LOCK
    } state_e;

    // Phase counter stops at the all-ones value instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == ACC_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/coilgun_core_if.sv
// Trigger/sensor/config inputs and coil-driver outputs of one coilgun stage.
interface coilgun_core_if import cg_core_pkg::*; ();

    logic          I_TRIG;
    logic          I_GATE;
    logic [CW-1:0] I_LMT;
    logic [CW-1:0] I_DLY;
    logic          I_OE;
    logic          I_EN;
    logic          I_DDS;
    logic          I_LDS;
    logic          I_LEN;
    logic          O_EXT;
    logic          O_SOE;
    logic          O_RTE;
    logic [CW-1:0] O_ACC;

    modport master (
        output I_TRIG, I_GATE, I_LMT, I_DLY, I_OE, I_EN, I_DDS, I_LDS, I_LEN,
        input  O_EXT, O_SOE, O_RTE, O_ACC
    );

    modport slave (
        input  I_TRIG, I_GATE, I_LMT, I_DLY, I_OE, I_EN, I_DDS, I_LDS, I_LEN,
        output O_EXT, O_SOE, O_RTE, O_ACC
    );

endinterface

// File: rtl/coilgun_core_edge_det.sv
// One-cycle history register with combinational rise/fall detection.
module cg_edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic q;

    always_ff @(posedge clk) begin
        if (rst) q <= RST_VAL;
        else     q <= d;
    end

    assign rise = d & ~q;
    assign fall = ~d & q;

endmodule

// File: rtl/coilgun_core.sv
// Single-stage coilgun controller: arm on trigger edge, delay, fire window,
// chain pulse, then lock out until the trigger is released.
module coilgun_core import cg_core_pkg::*; (
    input  logic          clk,
    input  logic          I_RST,
    coilgun_core_if.slave bus
);

    state_e        state, state_n;
    logic [CW-1:0] acc, acc_n;
    logic          ext_q, ext_n;
    logic          trig_rise, gate_rise, gate_fall;
    logic [CW-1:0] lim_last;
    logic          lim_end, dly_end, fire_end;

    // Trigger history resets high so a trigger held through reset cannot fire.
    cg_edge_det #(.RST_VAL(1'b1)) u_trig_edge (
        .clk (clk),
        .rst (I_RST),
        .d   (bus.I_TRIG),
        .rise(trig_rise),
        .fall()
    );

    cg_edge_det #(.RST_VAL(1'b0)) u_gate_edge (
        .clk (clk),
        .rst (I_RST),
        .d   (bus.I_GATE),
        .rise(gate_rise),
        .fall(gate_fall)
    );

    assign lim_last = (bus.I_LMT == '0) ? '0 : bus.I_LMT - 1'b1;
    assign lim_end  = (acc == lim_last);
    assign dly_end  = (acc == bus.I_DLY - 1'b1);
    assign fire_end = bus.I_LDS ? lim_end : (gate_fall | (bus.I_LEN & lim_end));

    always_ff @(posedge clk) begin
        if (I_RST) begin
            state <= IDLE;
            acc   <= '0;
            ext_q <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            ext_q <= ext_n;
        end
    end

    // The counter clears on every phase change, so only "stay" paths count.
    always_comb begin
        state_n = state;
        acc_n   = '0;
        ext_n   = 1'b0;
        case (state)
            IDLE: begin
                if (trig_rise)
                    state_n = (bus.I_DDS && bus.I_DLY == '0) ? FIRE : DELAY;
            end
            DELAY: begin
                if (bus.I_DDS ? dly_end : gate_rise) state_n = FIRE;
                else                                  acc_n   = sat_inc(acc);
            end
            FIRE: begin
                if (fire_end) begin
                    state_n = LOCK;
                    ext_n   = 1'b1;
                end else begin
                    acc_n = sat_inc(acc);
                end
            end
            LOCK: begin
                if (!bus.I_TRIG) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (!bus.I_EN) begin
            state_n = IDLE;
            acc_n   = '0;
            ext_n   = 1'b0;
        end
    end

    assign bus.O_SOE = (state == FIRE) & bus.I_OE & bus.I_EN;
    assign bus.O_RTE = (state == IDLE) & bus.I_EN & ~bus.I_TRIG;
    assign bus.O_EXT = ext_q;
    assign bus.O_ACC = acc;

endmodule

// File: tb/tb_coilgun_core.sv
// Randomized and directed bench for coilgun_core against a cycle-level
// behavioural model of the firing rules.
module tb_coilgun_core;

    localparam int P_IDLE  = 0;
    localparam int P_DELAY = 1;
    localparam int P_FIRE  = 2;
    localparam int P_LOCK  = 3;
    localparam int ACC_SAT = 16777215;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    int   m_phase;
    int   m_acc;
    bit   m_trig_q;
    bit   m_gate_q;
    bit   m_ext;

    coilgun_core_if cif ();

    coilgun_core dut (
        .clk  (clk),
        .I_RST(rst),
        .bus  (cif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit trig, input bit gate, input bit en, input bit oe,
                                 input bit dds, input bit lds, input bit len,
                                 input int lmt, input int dly);
        cif.I_TRIG = trig;
        cif.I_GATE = gate;
        cif.I_EN   = en;
        cif.I_OE   = oe;
        cif.I_DDS  = dds;
        cif.I_LDS  = lds;
        cif.I_LEN  = len;
        cif.I_LMT  = 24'(lmt);
        cif.I_DLY  = 24'(dly);
    endtask

    // Advance the reference by one clock using the inputs seen at the edge.
    task automatic modelStep();
        int nxt;
        int win;
        int dly_last;
        bit tr, gr, gf, lim_hit, ext_next;
        if (rst) begin
            m_phase  = P_IDLE;
            m_acc    = 0;
            m_trig_q = 1'b1;
            m_gate_q = 1'b0;
            m_ext    = 1'b0;
            return;
        end
        tr       = cif.I_TRIG && !m_trig_q;
        gr       = cif.I_GATE && !m_gate_q;
        gf       = !cif.I_GATE && m_gate_q;
        win      = (cif.I_LMT == 0) ? 1 : int'(cif.I_LMT);
        lim_hit  = (m_acc == win - 1);
        dly_last = (int'(cif.I_DLY) + ACC_SAT) % (ACC_SAT + 1);
        nxt      = m_phase;
        ext_next = 1'b0;
        if (m_phase == P_IDLE && tr)
            nxt = (cif.I_DDS && cif.I_DLY == 0) ? P_FIRE : P_DELAY;
        else if (m_phase == P_DELAY && (cif.I_DDS ? (m_acc == dly_last) : gr))
            nxt = P_FIRE;
        else if (m_phase == P_FIRE && (cif.I_LDS ? lim_hit : (gf || (cif.I_LEN && lim_hit)))) begin
            nxt      = P_LOCK;
            ext_next = 1'b1;
        end else if (m_phase == P_LOCK && !cif.I_TRIG)
            nxt = P_IDLE;
        if (!cif.I_EN) begin
            nxt      = P_IDLE;
            ext_next = 1'b0;
        end
        if (nxt != m_phase || nxt == P_IDLE || nxt == P_LOCK) m_acc = 0;
        else if (m_acc < ACC_SAT)                           m_acc = m_acc + 1;
        m_phase  = nxt;
        m_ext    = ext_next;
        m_trig_q = cif.I_TRIG;
        m_gate_q = cif.I_GATE;
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        checkOutput("soe", 32'(cif.O_SOE), 32'((m_phase == P_FIRE) && cif.I_OE && cif.I_EN));
        checkOutput("rte", 32'(cif.O_RTE), 32'((m_phase == P_IDLE) && cif.I_EN && !cif.I_TRIG));
        checkOutput("ext", 32'(cif.O_EXT), 32'(m_ext));
        checkOutput("acc", 32'(cif.O_ACC), 32'(m_acc));
    endtask

    // Called on the first O_SOE cycle; counts the window, then expects the chain pulse.
    task automatic measureWidth(input int exp_w, input string tag);
        int w = 0;
        for (int i = 0; i < 200; i++) begin
            if (!cif.O_SOE) break;
            w++;
            tick();
        end
        checkOutput(tag, 32'(w), 32'(exp_w));
        checkOutput({tag, "_ext"}, 32'(cif.O_EXT), 32'd1);
    endtask

    task automatic measureFire(input int lmt, input int dly);
        int lat = 0;
        cif.I_LMT  = 24'(lmt);
        cif.I_DLY  = 24'(dly);
        cif.I_TRIG = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            lat++;
            if (cif.O_SOE) break;
        end
        checkOutput("fire_latency", 32'(lat), 32'(dly + 1));
        measureWidth((lmt == 0) ? 1 : lmt, "fire_width");
        checkOutput("lock_rte", 32'(cif.O_RTE), 32'd0);
        cif.I_TRIG = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int cnt_ext;
        int cnt_soe;
        rst = 1'b1;
        applyStimulus(1, 0, 1, 1, 1, 1, 1, 1, 0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        checkOutput("held_trig_no_fire", 32'(cif.O_SOE), 32'd0);
        cif.I_TRIG = 1'b0;
        tick();

        $display("[TB] counted fire");
        measureFire(1, 0);
        measureFire(1, 0);
        measureFire(0, 0);
        $display("[TB] delayed fire");
        measureFire(3, 5);
        measureFire(4, 1);

        $display("[TB] gate mode");
        applyStimulus(0, 0, 1, 1, 0, 0, 0, 4, 0);
        tick();
        cif.I_TRIG = 1'b1;
        repeat (3) tick();
        cif.I_GATE = 1'b1;
        tick();
        checkOutput("gate_rise_soe", 32'(cif.O_SOE), 32'd1);
        repeat (5) tick();
        cif.I_GATE = 1'b0;
        tick();
        checkOutput("gate_fall_soe", 32'(cif.O_SOE), 32'd0);
        checkOutput("gate_fall_ext", 32'(cif.O_EXT), 32'd1);
        cif.I_TRIG = 1'b0;
        tick();
        cif.I_LEN  = 1'b1;
        cif.I_TRIG = 1'b1;
        repeat (2) tick();
        cif.I_GATE = 1'b1;
        tick();
        measureWidth(4, "gate_capped_width");
        cif.I_GATE = 1'b0;
        cif.I_TRIG = 1'b0;
        repeat (2) tick();

        $display("[TB] abort by enable and reset");
        applyStimulus(0, 0, 1, 1, 1, 1, 1, 20, 0);
        tick();
        cif.I_TRIG = 1'b1;
        repeat (3) tick();
        cif.I_EN = 1'b0;
        tick();
        checkOutput("abort_en_soe", 32'(cif.O_SOE), 32'd0);
        cif.I_EN = 1'b1;
        tick();
        checkOutput("abort_en_ext", 32'(cif.O_EXT), 32'd0);
        cif.I_TRIG = 1'b0;
        tick();
        cif.I_TRIG = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        checkOutput("abort_rst_soe", 32'(cif.O_SOE), 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("abort_rst_ext", 32'(cif.O_EXT), 32'd0);
        cif.I_TRIG = 1'b0;
        tick();

        $display("[TB] retrigger during fire and OE masking");
        cif.I_LMT  = 24'd6;
        cif.I_TRIG = 1'b1;
        tick();
        cnt_soe = 32'(cif.O_SOE);
        for (int i = 0; i < 4; i++) begin
            cif.I_TRIG = ~cif.I_TRIG;
            tick();
            cnt_soe += 32'(cif.O_SOE);
        end
        cif.I_TRIG = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            cnt_soe += 32'(cif.O_SOE);
        end
        checkOutput("retrig_soe_cycles", 32'(cnt_soe), 32'd6);
        cif.I_TRIG = 1'b0;
        tick();
        applyStimulus(0, 0, 1, 0, 1, 1, 1, 3, 2);
        tick();
        cif.I_TRIG = 1'b1;
        cnt_ext = 0;
        cnt_soe = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cnt_ext += 32'(cif.O_EXT);
            cnt_soe += 32'(cif.O_SOE);
        end
        checkOutput("oe_mask_ext_count", 32'(cnt_ext), 32'd1);
        checkOutput("oe_mask_soe_count", 32'(cnt_soe), 32'd0);
        cif.I_TRIG = 1'b0;
        tick();

        $display("[TB] randomized run");
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) cif.I_TRIG = ~cif.I_TRIG;
            if ($urandom_range(0, 5) == 0) cif.I_GATE = ~cif.I_GATE;
            if ($urandom_range(0, 29) == 0) {cif.I_DDS, cif.I_LDS, cif.I_LEN} = 3'($urandom);
            cif.I_EN  = ($urandom_range(0, 49) != 0);
            cif.I_OE  = ($urandom_range(0, 9) != 0);
            cif.I_LMT = 24'($urandom_range(0, 6));
            cif.I_DLY = 24'($urandom_range(0, 6));
            rst       = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/coilgun_core.md
# coilgun_core

Single-stage coilgun firing controller. It arms on a trigger edge, waits a programmable delay, then drives the coil stage-output-enable for a bounded fire window. It emits a chain pulse for the next stage and locks out until the trigger is released. It sits between the sensor/trigger front end and the coil driver, and is cascaded per stage through O_EXT.

## Interface
- CW, 24: counter/compare width; fixed by the codebase, not overridden.
- clk  in  1  system clock, all logic on rising edge.
- I_RST  in  1  reset; synchronous, active-high.
- I_TRIG  in  1  trigger input, rising-edge sensitive.
- I_GATE  in  1  sensor gate input, used when a phase is in gate mode.
- I_LMT  in  24  fire-window length in cycles (0 treated as 1).
- I_DLY  in  24  delay length in cycles.
- I_OE  in  1  output enable; masks O_SOE.
- I_EN  in  1  core enable; low aborts to IDLE.
- I_DDS  in  1  delay source: 1 = counted (I_DLY), 0 = ends on I_GATE rising edge.
- I_LDS  in  1  fire-end source: 1 = counted (I_LMT), 0 = ends on I_GATE falling edge.
- I_LEN  in  1  limit enable: in gate mode (I_LDS=0), I_LMT also caps fire length.
- O_EXT  out  1  one-cycle chain pulse at fire end.
- O_SOE  out  1  stage output enable to coil driver.
- O_RTE  out  1  ready-to-engage (armed).
- O_ACC  out  24  current phase counter.

## Operation
- States: IDLE, DELAY, FIRE, LOCK.
- trig_rise = I_TRIG & ~trig_q. trig_q is registered every cycle and resets to 1, so a trigger held high through reset does not fire.
- IDLE: ACC = 0. On trig_rise & I_EN, the next state is determined as follows.
  - DDS=1 and I_DLY=0: go to FIRE.
  - Otherwise: go to DELAY. ACC clears on any state change.
- DELAY:
  - DDS=1: ACC increments. Go to FIRE when ACC == I_DLY-1, so DELAY lasts I_DLY cycles.
  - DDS=0: go to FIRE on I_GATE rising edge (gate_q registered).
- FIRE:
  - LDS=1: end when ACC == max(I_LMT,1)-1.
  - LDS=0: end on I_GATE falling edge, or on the counted limit if I_LEN=1.
  - At the end: pulse O_EXT and go to LOCK.
- LOCK: stay while I_TRIG high; go to IDLE on the first cycle I_TRIG is sampled low.
- ACC increments by 1 in DELAY and FIRE and saturates at 24'hFFFFFF; it is 0 in IDLE and LOCK.
- I_EN low in any state: next state IDLE, ACC 0, no O_EXT pulse. This has priority over all transitions except I_RST.
- Outputs:
  - O_SOE = (state==FIRE) & I_OE & I_EN.
  - O_RTE = (state==IDLE) & I_EN & ~I_TRIG.
  - O_EXT registered, high exactly one cycle, the cycle after FIRE exits normally.
- I_LMT, I_DLY and the mode inputs are sampled live each cycle; changes mid-phase take effect on the next compare.

## Timing
- Reset: state IDLE, ACC 0, trig_q 1, gate_q 0, O_EXT 0, O_SOE 0. O_RTE follows its equation after reset.
- Reset mid-fire: O_SOE drops the cycle after I_RST is sampled high.
- Trigger latency: I_TRIG high sampled at edge N (low at N-1) → state DELAY/FIRE after edge N.
- With DLY=0 and DDS=1, O_SOE is high in the cycle after edge N.
- Fire window (LDS=1): O_SOE high for exactly max(I_LMT,1) cycles. O_EXT is high in the cycle immediately following the last O_SOE cycle.
- Simultaneous end-of-delay gate edge and I_EN low: I_EN wins.
- Simultaneous gate end and limit end: single exit, single O_EXT pulse.
- A retrigger during DELAY/FIRE/LOCK is ignored; a new fire requires LOCK → IDLE and a fresh rising edge.

## Structure
- Package cg_core_pkg holds:
  - the state enum {IDLE, DELAY, FIRE, LOCK};
  - localparam CW = 24;
  - the saturation constant ACC_MAX.
- One sub-module, cg_edge_det (register plus rise/fall outputs, configurable reset value), instanced for I_TRIG (reset 1) and I_GATE (reset 0).
- Top contains the FSM, saturating counter and output logic.

## Test plan
- Counted fire: EN=OE=DDS=LDS=LEN=1, LMT=1, DLY=0; reset, then TRIG 0→1. Required response: O_SOE high exactly 1 cycle, then O_EXT 1 cycle, O_RTE low until TRIG is low. Drop TRIG, raise again → second identical fire.
- Delay: DLY=5, LMT=3. Required response: O_SOE rises 6 cycles after the trigger edge, stays high 3 cycles, ACC counts 0..4 then 0..2.
- Gate mode: DDS=0, LDS=0, LEN=0. Required response: O_SOE rises the cycle after the I_GATE rising edge and falls the cycle after the I_GATE falling edge. With LEN=1 and LMT=4, a long gate is cut at 4 cycles.
- Abort: drop I_EN mid-FIRE. Required response: O_SOE low next cycle, no O_EXT, state IDLE. Same result for I_RST mid-FIRE.
- Lockout/reset safety: TRIG held high through reset release → no fire. Retrigger pulses during FIRE are ignored.
- OE masking: I_OE=0. Required response: full sequence and O_EXT still occur, O_SOE stays 0.
